spad_frame_accumulator: RTL and testbench



---
 rtl/spad_frame_accumulator_pkg.sv | 22 ++
 rtl/spad_count_mem.sv | 40 ++++
 rtl/spad_frame_accumulator.sv | 164 ++++++++++++++++
 tb/tb_spad_frame_accumulator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spad_frame_accumulator_pkg.sv
// Shared constants for the SPAD frame accumulator.
// - FSM state encodings (IDLE, CLEAR, SYNC, ACCUM, DONE)
// - Pixel word field positions, identical to the readout FSM's word packing
// - NPIX: pixels per frame
package spad_frame_accumulator_pkg;

    localparam int NPIX = 512;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SYNC  = 3'd2;
    localparam logic [2:0] ST_ACCUM = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // 16-bit FIFO word: [15:6] pixel address, [5] always 0, [4:0] pixel value
    localparam int ADDR_HI  = 15;
    localparam int ADDR_LO  = 6;
    localparam int ZERO_BIT = 5;
    localparam int DATA_HI  = 4;
    localparam int DATA_LO  = 0;

endpackage

// File: rtl/spad_count_mem.sv
// NPIX x CNT_W count memory.
// - i_we/i_waddr/i_wdata : write port (clear or accumulate)
// - i_raddr/o_rdata      : combinational read for the read-modify-write path
// - i_host_addr/o_host_data : registered host read, 1-cycle latency
// Contents are not reset; only the host read register is.
module spad_count_mem #(
    parameter int NPIX  = 512,
    parameter int CNT_W = 16,
    parameter int AW    = $clog2(NPIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [CNT_W-1:0] o_rdata,
    input  logic [AW-1:0]    i_host_addr,
    output logic [CNT_W-1:0] o_host_data
);

    logic [CNT_W-1:0] r_mem [NPIX];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read and write share one cycle, so consecutive words to the same
    // pixel always see the value written on the previous edge.
    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_host_data <= '0;
        else
            o_host_data <= r_mem[i_host_addr];
    end

endmodule

// File: rtl/spad_frame_accumulator.sv
// SPAD frame accumulator: pops pixel words from the readout FIFO, checks the
// address sequence 0..NPIX-1 and sums the 5-bit values per pixel over a
// programmable number of frames. Host reads counts through rd_addr/rd_data.
// Ports:
// - clk, rst (async, active-high)
// - start, frames_to_sum : begin a new run (0 frames treated as 1)
// - fifo_dout, fifo_empty, fifo_rd_en : FIFO read side, 1-cycle read latency
// - rd_addr, rd_data : host read port, registered
// - busy, done, seq_err, err_cnt, frame_cnt : status
module spad_frame_accumulator
    import spad_frame_accumulator_pkg::*;
#(
    parameter int  NPIX  = spad_frame_accumulator_pkg::NPIX,
    parameter int  CNT_W = 16,
    parameter int  FRM_W = 16,
    parameter int  ERR_W = 8,
    localparam int AW    = $clog2(NPIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [FRM_W-1:0] frames_to_sum,
    input  logic [15:0]      fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [FRM_W-1:0] frame_cnt
);

    logic [2:0]       r_state;
    logic [AW-1:0]    r_clr_idx;
    logic [AW-1:0]    r_exp_addr;
    logic [FRM_W-1:0] r_frames_eff;
    logic             r_word_vld;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic [FRM_W-1:0] r_frame_cnt;

    logic [ADDR_HI-ADDR_LO:0] w_addr;
    logic [DATA_HI-DATA_LO:0] w_val;
    logic [AW-1:0]    w_pix;
    logic [AW-1:0]    w_exp;
    logic             w_zero;
    logic             w_in_pop;
    logic             w_proc;
    logic             w_good;
    logic             w_bad;
    logic             w_last;
    logic             w_final;
    logic [FRM_W-1:0] w_frm_inc;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_sat;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [CNT_W-1:0] w_wdata;

    assign w_addr = fifo_dout[ADDR_HI:ADDR_LO];
    assign w_zero = fifo_dout[ZERO_BIT];
    assign w_val  = fifo_dout[DATA_HI:DATA_LO];
    assign w_pix  = w_addr[AW-1:0];

    assign w_in_pop = (r_state == ST_SYNC) || (r_state == ST_ACCUM);

    // SYNC only looks at words addressed to pixel 0 and treats them exactly
    // like ACCUM with an expected address of 0; everything else is discarded.
    assign w_exp  = (r_state == ST_SYNC) ? '0 : r_exp_addr;
    assign w_proc = r_word_vld && !start &&
                    ((r_state == ST_ACCUM) || ((r_state == ST_SYNC) && (w_addr == '0)));
    // Full-width compare also rejects address bit 9 and out-of-range pixels.
    assign w_good = w_proc && (w_addr == (ADDR_HI-ADDR_LO+1)'(w_exp)) && !w_zero;
    assign w_bad  = w_proc && !w_good;

    assign w_frm_inc = r_frame_cnt + 1'b1;
    assign w_last    = w_good && (w_pix == AW'(NPIX-1));
    assign w_final   = w_last && (w_frm_inc == r_frames_eff);

    // The final word of the run blocks the pop in its own cycle so nothing
    // beyond the requested frames leaves the FIFO.
    assign fifo_rd_en = w_in_pop && !fifo_empty && !w_final;

    assign w_sum = {1'b0, w_rd_cnt} + (CNT_W+1)'(w_val);
    assign w_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    assign w_we    = (r_state == ST_CLEAR) || w_good;
    assign w_waddr = (r_state == ST_CLEAR) ? r_clr_idx : w_pix;
    assign w_wdata = (r_state == ST_CLEAR) ? '0 : w_sat;

    spad_count_mem #(
        .NPIX  (NPIX),
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_mem (
        .clk         (clk),
        .rst         (rst),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_raddr     (w_pix),
        .o_rdata     (w_rd_cnt),
        .i_host_addr (rd_addr),
        .o_host_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_clr_idx    <= '0;
            r_exp_addr   <= '0;
            r_frames_eff <= '0;
            r_word_vld   <= 1'b0;
            r_seq_err    <= 1'b0;
            r_err_cnt    <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_word_vld <= fifo_rd_en;
            if (start) begin
                r_state      <= ST_CLEAR;
                r_clr_idx    <= '0;
                r_exp_addr   <= '0;
                r_frames_eff <= (frames_to_sum == '0) ? FRM_W'(1) : frames_to_sum;
                r_seq_err    <= 1'b0;
                r_err_cnt    <= '0;
                r_frame_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_CLEAR: begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                        if (r_clr_idx == AW'(NPIX-1))
                            r_state <= ST_SYNC;
                    end
                    ST_SYNC, ST_ACCUM: begin
                        if (w_good) begin
                            r_state    <= w_final ? ST_DONE : ST_ACCUM;
                            r_exp_addr <= w_last ? '0 : w_pix + 1'b1;
                            if (w_last)
                                r_frame_cnt <= w_frm_inc;
                        end else if (w_bad) begin
                            // Partial frame keeps what it added but is not counted.
                            r_state    <= ST_SYNC;
                            r_exp_addr <= '0;
                            r_seq_err  <= 1'b1;
                            if (r_err_cnt != '1)
                                r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (r_state == ST_CLEAR) || w_in_pop;
    assign done      = (r_state == ST_DONE);
    assign seq_err   = r_seq_err;
    assign err_cnt   = r_err_cnt;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_spad_frame_accumulator.sv
// Directed bench for spad_frame_accumulator: a 16-bit-count instance and an
// 8-bit-count instance, each fed from its own queue-modelled FIFO.
module tb_spad_frame_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, start8 = 1'b0;
    logic [15:0] fts = '0, fts8 = '0;
    logic [15:0] dout = '0, dout8 = '0;
    logic        empty = 1'b1, empty8 = 1'b1;
    logic        rd_en, rd_en8;
    logic [8:0]  rd_addr = '0, rd_addr8 = '0;
    logic [15:0] rd_data;
    logic [7:0]  rd_data8;
    logic        busy, done, seq_err, busy8, done8, seq_err8;
    logic [7:0]  err_cnt, err_cnt8;
    logic [15:0] frame_cnt, frame_cnt8;

    logic [15:0] q[$];
    logic [15:0] q8[$];
    bit stall_en = 1'b0;
    int pops = 0, pops8 = 0, viol = 0;
    int n_tests = 0, n_fail = 0;

    spad_frame_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .frames_to_sum(fts),
        .fifo_dout(dout), .fifo_empty(empty), .fifo_rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .seq_err(seq_err), .err_cnt(err_cnt), .frame_cnt(frame_cnt)
    );

    spad_frame_accumulator #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .frames_to_sum(fts8),
        .fifo_dout(dout8), .fifo_empty(empty8), .fifo_rd_en(rd_en8),
        .rd_addr(rd_addr8), .rd_data(rd_data8), .busy(busy8), .done(done8),
        .seq_err(seq_err8), .err_cnt(err_cnt8), .frame_cnt(frame_cnt8)
    );

    // FIFO models: pop on the edge that samples rd_en, data valid next cycle.
    always @(posedge clk) begin
        if (rd_en && empty) viol++;
        if (rd_en && q.size() > 0) begin
            dout <= q.pop_front();
            pops++;
        end
        if (rd_en8 && q8.size() > 0) begin
            dout8 <= q8.pop_front();
            pops8++;
        end
    end

    always @(negedge clk) begin
        empty  = (q.size() == 0) || (stall_en && ($urandom_range(0, 1) == 1));
        empty8 = (q8.size() == 0);
    end

    function automatic logic [15:0] mkword(input int a, input int v);
        logic [9:0] aa;
        logic [4:0] vv;
        aa = 10'(a);
        vv = 5'(v);
        return {aa, 1'b0, vv};
    endfunction

    task automatic pulse_start(input logic [15:0] f);
        @(negedge clk); fts = f; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_start8(input logic [15:0] f);
        @(negedge clk); fts8 = f; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
    endtask

    task automatic read_cnt(input int a, output logic [15:0] d);
        rd_addr = 9'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err got=%0b exp=0", seq_err); end
        n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en); end
        n_tests++; if (rd_data !== 16'd0) begin n_fail++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [15:0] d;
        int bad = 0;
        pops = 0;
        for (int i = 0; i < 512; i++) q.push_back(mkword(i, i % 32));
        pulse_start(16'd1);
        wait_done(1500);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done got=%0b exp=1", done); end
        n_tests++; if (pops != 512) begin n_fail++; $display("FAIL single_pops got=%0d exp=512", pops); end
        n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_frame_cnt got=%0d exp=1", frame_cnt); end
        n_tests++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL single_seq_err got=%0b exp=0", seq_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%0b exp=0", busy); end
        read_cnt(37, d);
        n_tests++; if (d !== 16'd5) begin n_fail++; $display("FAIL single_rd37 got=%0d exp=5", d); end
        for (int i = 0; i < 512; i++) begin
            read_cnt(i, d);
            if (d !== 16'(i % 32)) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL single_sweep bad_entries=%0d exp=0", bad); end
    endtask

    task automatic test_multi_frame();
        logic [15:0] d;
        int bad = 0;
        pops = 0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 512; i++) q.push_back(mkword(i, 31));
        pulse_start(16'd3);
        wait_done(3000);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL multi_done got=%0b exp=1", done); end
        repeat (5) @(negedge clk);
        n_tests++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL multi_frame_cnt got=%0d exp=3", frame_cnt); end
        n_tests++; if (pops != 1536) begin n_fail++; $display("FAIL multi_pops got=%0d exp=1536", pops); end
        n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL multi_rd_en_in_done got=%0b exp=0", rd_en); end
        n_tests++; if (q.size() != 512) begin n_fail++; $display("FAIL multi_left_in_fifo got=%0d exp=512", q.size()); end
        for (int i = 0; i < 512; i++) begin
            read_cnt(i, d);
            if (d !== 16'd93) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL multi_sweep bad_entries=%0d exp=0", bad); end
        q.delete();
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int bad = 0;
        pops8 = 0;
        for (int f = 0; f < 9; f++)
            for (int i = 0; i < 512; i++) q8.push_back(mkword(i, 31));
        pulse_start8(16'd9);
        for (int i = 0; i < 6000 && !done8; i++) @(negedge clk);
        n_tests++; if (done8 !== 1'b1) begin n_fail++; $display("FAIL sat_done got=%0b exp=1", done8); end
        n_tests++; if (frame_cnt8 !== 16'd9) begin n_fail++; $display("FAIL sat_frame_cnt got=%0d exp=9", frame_cnt8); end
        n_tests++; if (pops8 != 4608) begin n_fail++; $display("FAIL sat_pops got=%0d exp=4608", pops8); end
        for (int i = 0; i < 512; i++) begin
            rd_addr8 = 9'(i);
            @(negedge clk);
            if (rd_data8 !== 8'd255) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sat_sweep bad_entries=%0d exp=0", bad); end
    endtask

    task automatic test_seq_err();
        logic [15:0] d;
        int bad = 0;
        int e;
        pops = 0;
        for (int i = 0; i < 512; i++) if (i != 100) q.push_back(mkword(i, i % 32));
        for (int i = 0; i < 512; i++) q.push_back(mkword(i, i % 32));
        pulse_start(16'd1);
        wait_done(3000);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL seq_done got=%0b exp=1", done); end
        n_tests++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_seq_err got=%0b exp=1", seq_err); end
        n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_err_cnt got=%0d exp=1", err_cnt); end
        n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL seq_frame_cnt got=%0d exp=1", frame_cnt); end
        n_tests++; if (pops != 1023) begin n_fail++; $display("FAIL seq_pops got=%0d exp=1023", pops); end
        for (int i = 0; i < 512; i++) begin
            e = (i < 100) ? 2 * (i % 32) : i % 32;
            read_cnt(i, d);
            if (d !== 16'(e)) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL seq_sweep bad_entries=%0d exp=0", bad); end
    endtask

    task automatic test_empty_toggle();
        logic [15:0] d;
        int bad = 0;
        pops = 0;
        viol = 0;
        stall_en = 1'b1;
        for (int i = 0; i < 512; i++) q.push_back(mkword(i, i % 32));
        pulse_start(16'd1);
        wait_done(5000);
        stall_en = 1'b0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL toggle_done got=%0b exp=1", done); end
        n_tests++; if (pops != 512) begin n_fail++; $display("FAIL toggle_pops got=%0d exp=512", pops); end
        n_tests++; if (viol != 0) begin n_fail++; $display("FAIL toggle_pop_while_empty got=%0d exp=0", viol); end
        n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL toggle_frame_cnt got=%0d exp=1", frame_cnt); end
        for (int i = 0; i < 512; i++) begin
            read_cnt(i, d);
            if (d !== 16'(i % 32)) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL toggle_sweep bad_entries=%0d exp=0", bad); end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        int bad = 0;
        int k = 0;
        pops = 0;
        for (int i = 0; i < 512; i++) q.push_back(mkword(i, 1));
        for (int i = 0; i < 200; i++) q.push_back(mkword(i, 1));
        pulse_start(16'd2);
        for (int i = 0; i < 2000 && pops < 712; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_pre_frame_cnt got=%0d exp=1", frame_cnt); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got=%0b exp=1", busy); end
        pulse_start(16'd1);
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL abort_frame_cnt got=%0d exp=0", frame_cnt); end
        repeat (520) @(negedge clk);
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL abort_sync_state busy=%0b done=%0b exp busy=1 done=0", busy, done); end
        for (int i = 0; i < 512; i++) begin
            read_cnt(i, d);
            if (d !== 16'd0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL abort_cleared bad_entries=%0d exp=0", bad); end
        // Restart with data queued: no pop until the 512-cycle clear ends.
        pulse_start(16'd1);
        for (int i = 0; i < 512; i++) q.push_back(mkword(i, i % 32));
        while (!rd_en && k < 600) begin @(negedge clk); k++; end
        n_tests++; if (k != 512) begin n_fail++; $display("FAIL abort_clear_cycles got=%0d exp=512", k); end
        repeat (100) @(negedge clk);
        // Async reset mid-ACCUM, asserted away from any clock edge.
        #2 rst = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl busy=%0b done=%0b rd_en=%0b exp all 0", busy, done, rd_en); end
        n_tests++; if (seq_err !== 1'b0 || err_cnt !== 8'd0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_status seq_err=%0b err_cnt=%0d frame_cnt=%0d exp all 0", seq_err, err_cnt, frame_cnt); end
        n_tests++; if (rd_data !== 16'd0) begin n_fail++; $display("FAIL rst_rd_data got=%0d exp=0", rd_data); end
        @(negedge clk);
        rst = 1'b0;
        k = pops;
        repeat (5) @(negedge clk);
        n_tests++; if (pops != k || rd_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle pops_delta=%0d rd_en=%0b busy=%0b exp 0", pops - k, rd_en, busy); end
        q.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_multi_frame();
        test_saturate();
        test_seq_err();
        test_empty_toggle();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
